// File: rtl/axi_dma_wr_burst_if.sv
// AXI4 write-channel bundle (AW, W and B) between the DMA write master and the interconnect.
interface axi_dma_wr_burst_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_dma_wr_burst.sv
// AXI4 write DMA master: stream beats to memory as INCR bursts with bounded outstanding B responses.
// Define AXI_DMA_4K_SPLIT_EN to additionally split bursts at 4 KB address boundaries.
module axi_dma_wr_burst #(
    parameter int          M_AXI_ID_WIDTH   = 1,
    parameter int unsigned M_AXI_ID         = 0,
    parameter int          M_AXI_ADDR_WIDTH = 32,
    parameter int          M_AXI_DATA_WIDTH = 128,
    parameter int          MAX_BURST_LEN    = 256,
    parameter int          MAX_OUTSTANDING  = 4
) (
    input  logic                        M_AXI_ACLK,
    input  logic                        M_AXI_ARESETN,
    input  logic [M_AXI_ADDR_WIDTH-1:0] fdma_w_addr,
    input  logic                        fdma_w_areq,
    input  logic [31:0]                 fdma_w_size,
    output logic                        fdma_w_busy,
    output logic                        fdma_w_err,
    input  logic [M_AXI_DATA_WIDTH-1:0] fdma_w_data,
    input  logic                        fdma_w_ready,
    output logic                        fdma_w_valid,
    axi_dma_wr_burst_if.master          m_axi
);
    localparam int AXI_BYTES  = M_AXI_DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(AXI_BYTES);
    localparam int LEN_W      = $clog2(MAX_BURST_LEN) + 1;
    localparam int OUT_W      = 4;

    // IDLE wait request | CALC size next burst | AW address phase | DATA finish beats | DRAIN wait all B
    typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_DATA, S_DRAIN} state_t;

    state_t                      state;
    logic [M_AXI_ADDR_WIDTH-1:0] addr;
    logic [31:0]                 beats_left;
    logic [LEN_W-1:0]            len;
    logic [LEN_W-1:0]            beat_cnt;
    logic [OUT_W-1:0]            outstanding;
    logic                        aw_pend;
    logic                        w_en;
    logic                        busy;
    logic                        err;

    logic [31:0]                 len_calc;
    logic [M_AXI_ADDR_WIDTH-1:0] burst_bytes;
    logic                        wlast;
    logic                        wvalid;
    logic                        aw_hs;
    logic                        w_hs;
    logic                        last_hs;
    logic                        b_hs;
    logic                        unused_bits;

`ifdef AXI_DMA_4K_SPLIT_EN
    logic [12:0] beats_to_4k;
    assign beats_to_4k = (13'h1000 - {1'b0, addr[11:0]}) >> BYTE_SHIFT;
`endif

    always_comb begin
        len_calc = (beats_left < 32'(MAX_BURST_LEN)) ? beats_left : 32'(MAX_BURST_LEN);
`ifdef AXI_DMA_4K_SPLIT_EN
        if (32'(beats_to_4k) < len_calc) len_calc = 32'(beats_to_4k);
`endif
    end

    assign burst_bytes = M_AXI_ADDR_WIDTH'(len) << BYTE_SHIFT;
    assign wlast       = w_en && (beat_cnt == len - LEN_W'(1));
    assign wvalid      = w_en && fdma_w_ready;
    assign aw_hs       = aw_pend && m_axi.awready;
    assign w_hs        = wvalid && m_axi.wready;
    assign last_hs     = w_hs && wlast;
    // Guard keeps a stray response after an abandoned transfer from wrapping the counter.
    assign b_hs        = m_axi.bvalid && (outstanding != '0);
    assign unused_bits = ^{m_axi.bid, m_axi.bresp[0]};

    assign m_axi.awid    = M_AXI_ID_WIDTH'(M_AXI_ID);
    assign m_axi.awaddr  = addr;
    assign m_axi.awlen   = 8'(len - LEN_W'(1));
    assign m_axi.awsize  = 3'(BYTE_SHIFT);
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0010;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awqos   = 4'b0000;
    assign m_axi.awvalid = aw_pend;
    assign m_axi.wdata   = fdma_w_data;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = wlast;
    assign m_axi.wvalid  = wvalid;
    assign m_axi.bready  = 1'b1;

    assign fdma_w_busy  = busy;
    assign fdma_w_err   = err;
    assign fdma_w_valid = w_hs;

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state       <= S_IDLE;
            addr        <= '0;
            beats_left  <= '0;
            len         <= '0;
            beat_cnt    <= '0;
            outstanding <= '0;
            aw_pend     <= 1'b0;
            w_en        <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fdma_w_areq && (fdma_w_size != 32'd0)) begin
                        addr       <= fdma_w_addr & ~M_AXI_ADDR_WIDTH'(AXI_BYTES - 1);
                        beats_left <= fdma_w_size;
                        busy       <= 1'b1;
                        err        <= 1'b0;
                        state      <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (outstanding != OUT_W'(MAX_OUTSTANDING)) begin
                        len      <= LEN_W'(len_calc);
                        beat_cnt <= '0;
                        aw_pend  <= 1'b1;
                        w_en     <= 1'b1;
                        state    <= S_AW;
                    end
                end
                S_AW: begin
                    if (aw_hs) begin
                        aw_pend <= 1'b0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    // The burst may have finished its beats while still in S_AW; addr only moves once AW is done.
                    if (!w_en || last_hs) begin
                        addr       <= addr + burst_bytes;
                        beats_left <= beats_left - 32'(len);
                        state      <= (beats_left == 32'(len)) ? S_DRAIN : S_CALC;
                    end
                end
                S_DRAIN: begin
                    if (outstanding == '0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (w_hs) begin
                if (wlast) begin
                    w_en     <= 1'b0;
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + LEN_W'(1);
                end
            end

            if (aw_hs && !b_hs)      outstanding <= outstanding + OUT_W'(1);
            else if (!aw_hs && b_hs) outstanding <= outstanding - OUT_W'(1);

            if (b_hs && m_axi.bresp[1]) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_dma_wr_burst.sv
// Randomized bench for axi_dma_wr_burst: slave/producer stubs plus a burst-list reference model.
module tb_axi_dma_wr_burst;
    localparam int MBL = 16;
    localparam int MO  = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  fdma_w_addr;
    logic         fdma_w_areq;
    logic [31:0]  fdma_w_size;
    logic         fdma_w_busy;
    logic         fdma_w_err;
    logic [127:0] fdma_w_data;
    logic         fdma_w_ready;
    logic         fdma_w_valid;

    axi_dma_wr_burst_if #(.ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(128)) axi ();

    axi_dma_wr_burst #(
        .M_AXI_ID_WIDTH(1), .M_AXI_ID(0), .M_AXI_ADDR_WIDTH(32), .M_AXI_DATA_WIDTH(128),
        .MAX_BURST_LEN(MBL), .MAX_OUTSTANDING(MO)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .fdma_w_addr(fdma_w_addr), .fdma_w_areq(fdma_w_areq), .fdma_w_size(fdma_w_size),
        .fdma_w_busy(fdma_w_busy), .fdma_w_err(fdma_w_err), .fdma_w_data(fdma_w_data),
        .fdma_w_ready(fdma_w_ready), .fdma_w_valid(fdma_w_valid), .m_axi(axi)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_addr[$];
    int          exp_len[$];
    int          aw_cnt, wl_cnt, w_beats, beat_in_burst, b_cnt, b_sent, fv_cnt, prod_idx;
    int          err_burst, cur_size, w_hold;
    logic        exp_err, prod_adv, b_block;
    logic [31:0] data_tag;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] pattern(input int k);
        return {4{data_tag + 32'(k)}};
    endfunction

    // Burst list from the rules: cap by MBL, remaining beats and (optionally) the 4 KB page.
    task automatic build_model(input logic [31:0] a, input int unsigned size);
        logic [31:0] cur;
        int unsigned left, l, to4k;
        exp_addr.delete();
        exp_len.delete();
        cur  = a & ~32'hF;
        left = size;
        while (left > 0) begin
            l = (left < MBL) ? left : MBL;
            to4k = (4096 - (cur % 4096)) / 16;
`ifdef AXI_DMA_4K_SPLIT_EN
            if (to4k < l) l = to4k;
`endif
            exp_addr.push_back(cur);
            exp_len.push_back(int'(l));
            cur  = cur + l * 16;
            left = left - l;
        end
    endtask

    task automatic clear_counters();
        aw_cnt = 0; wl_cnt = 0; w_beats = 0; beat_in_burst = 0;
        b_cnt = 0; b_sent = 0; fv_cnt = 0; prod_idx = 0; prod_adv = 1'b0;
    endtask

    // Monitor: decide handshakes half a cycle before the edge that completes them.
    always @(negedge clk) begin
        int blen;
        if (rst_n) begin
            if (axi.bvalid) begin
                check_eq("bready", axi.bready, 1'b1);
                b_cnt++;
            end
            if (axi.awvalid && axi.awready) begin
                if (aw_cnt < exp_addr.size()) begin
                    check_eq("awaddr", axi.awaddr, exp_addr[aw_cnt]);
                    check_eq("awlen", axi.awlen, 128'(exp_len[aw_cnt] - 1));
                end else begin
                    check_eq("aw_extra", aw_cnt, exp_addr.size());
                end
                check_eq("aw_order", wl_cnt >= aw_cnt, 1'b1);
                check_eq("aw_outstanding", (aw_cnt - b_cnt) < MO, 1'b1);
                check_eq("aw_const", {axi.awid, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot, axi.awqos},
                         {1'b0, 3'd4, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000});
                aw_cnt++;
            end
            if (axi.wvalid && axi.wready) begin
                blen = (wl_cnt < exp_len.size()) ? exp_len[wl_cnt] : 0;
                check_eq("wdata", axi.wdata, pattern(w_beats));
                check_eq("wlast", axi.wlast, beat_in_burst == blen - 1);
                check_eq("wstrb", axi.wstrb, 16'hFFFF);
                check_eq("wvalid_gated", fdma_w_ready, 1'b1);
                w_beats++;
                if (beat_in_burst == blen - 1) begin
                    wl_cnt++;
                    beat_in_burst = 0;
                end else begin
                    beat_in_burst++;
                end
            end
            if (fdma_w_valid) begin
                fv_cnt++;
                prod_adv = 1'b1;
            end
        end
    end

    // Slave and producer stubs, driven just after each edge.
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
            fdma_w_ready = 1'b0; w_hold = 0;
        end else begin
            if (prod_adv) begin
                prod_idx++;
                prod_adv = 1'b0;
            end
            fdma_w_data  = pattern(prod_idx);
            fdma_w_ready = ($urandom_range(0, 4) != 0);
            axi.awready  = ($urandom_range(0, 3) != 0);
            if (w_hold > 0) begin
                axi.wready = 1'b0;
                w_hold--;
            end else begin
                axi.wready = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 60) == 0) w_hold = 10;
            end
            if (axi.bvalid) begin
                axi.bvalid = 1'b0;
            end else if (!b_block && b_sent < ((aw_cnt < wl_cnt) ? aw_cnt : wl_cnt) && $urandom_range(0, 2) != 0) begin
                axi.bvalid = 1'b1;
                axi.bresp  = (b_sent == err_burst) ? 2'b10 : 2'b00;
                b_sent++;
            end
        end
    end

    task automatic start_xfer(input logic [31:0] a, input int unsigned size, input int eb);
        build_model(a, size);
        @(posedge clk); #1;
        clear_counters();
        data_tag  = $urandom;
        err_burst = eb;
        cur_size  = int'(size);
        exp_err   = (eb >= 0) && (eb < exp_addr.size());
        fdma_w_addr = a; fdma_w_size = size; fdma_w_areq = 1'b1;
        @(posedge clk); #1;
        fdma_w_addr = $urandom; fdma_w_size = $urandom_range(1, 100);
        @(negedge clk);
        check_eq("busy_rise", fdma_w_busy, 1'b1);
        check_eq("err_clear", fdma_w_err, 1'b0);
        repeat (2) @(posedge clk);
        #1 fdma_w_areq = 1'b0;
    endtask

    task automatic finish_xfer();
        for (int i = 0; i < 5000 && fdma_w_busy; i++) @(negedge clk);
        check_eq("busy_fall", fdma_w_busy, 1'b0);
        check_eq("burst_count", aw_cnt, exp_addr.size());
        check_eq("last_count", wl_cnt, exp_addr.size());
        check_eq("beat_count", w_beats, cur_size);
        check_eq("fdma_valid_count", fv_cnt, cur_size);
        check_eq("b_count", b_cnt, exp_addr.size());
        check_eq("err_final", fdma_w_err, exp_err);
    endtask

    task automatic run_xfer(input logic [31:0] a, input int unsigned size, input int eb);
        start_xfer(a, size, eb);
        finish_xfer();
    endtask

    initial begin
        rst_n = 1'b0; fdma_w_addr = '0; fdma_w_areq = 1'b0; fdma_w_size = '0;
        fdma_w_data = '0; fdma_w_ready = 1'b0; b_block = 1'b0; err_burst = -1; data_tag = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 1'b0;
        clear_counters();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", fdma_w_busy, 1'b0);
        check_eq("rst_err", fdma_w_err, 1'b0);
        check_eq("rst_valids", {axi.awvalid, axi.wvalid, axi.wlast, fdma_w_valid}, 4'b0000);
        @(posedge clk); #1 rst_n = 1'b1;

        run_xfer(32'h0000_1000, 16, -1);
        run_xfer(32'h0000_0000, 40, -1);
        run_xfer(32'h0000_0F00, 40, -1);
        run_xfer(32'h0001_0000, 600, 1);
        repeat (5) @(negedge clk);
        check_eq("err_sticky", fdma_w_err, 1'b1);
        run_xfer(32'h0002_0010, 5, -1);

        @(posedge clk); #1 fdma_w_size = 0; fdma_w_areq = 1'b1;
        @(posedge clk); #1 fdma_w_areq = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("size0_ignored", {fdma_w_busy, axi.awvalid}, 2'b00);

        b_block = 1'b1;
        start_xfer(32'h0000_2000, 64, -1);
        repeat (150) @(negedge clk);
        check_eq("hold_aw_count", aw_cnt, 2);
        check_eq("hold_busy", fdma_w_busy, 1'b1);
        b_block = 1'b0;
        finish_xfer();

        for (int t = 0; t < 6; t++) begin
            int unsigned off, sz;
            int eb;
`ifndef AXI_DMA_4K_SPLIT_EN
            int unsigned lim;
`endif
            off = $urandom_range(0, 255) * 16;
`ifdef AXI_DMA_4K_SPLIT_EN
            sz = $urandom_range(1, 80);
`else
            lim = (4096 - off) / 16;
            if (lim > 80) lim = 80;
            sz = $urandom_range(1, lim);
`endif
            eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_xfer(($urandom_range(0, 15) << 12) | off, sz, eb);
        end

        start_xfer(32'h0000_3000, 64, -1);
        for (int i = 0; i < 300 && aw_cnt < 2; i++) @(negedge clk);
        check_eq("reset_reach_burst2", aw_cnt >= 2, 1'b1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 clear_counters();
        @(negedge clk);
        check_eq("midrst_busy_err", {fdma_w_busy, fdma_w_err}, 2'b00);
        check_eq("midrst_valids", {axi.awvalid, axi.wvalid, axi.wlast, fdma_w_valid}, 4'b0000);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run_xfer(32'h0000_4000, 8, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end
endmodule
